// File: rtl/mem_arb_pkg.sv
// Shared types and sizing constants for the main-memory arbiter.
package mem_arb_pkg;

  // Arbiter states: idle, single-cycle store, D-cache fill, I-cache fill.
  typedef enum logic [1:0] {
    StIdle  = 2'd0,
    StWrite = 2'd1,
    StFillD = 2'd2,
    StFillI = 2'd3
  } arb_state_t;

  // Default block geometry; memory words are two bytes wide.
  localparam int unsigned WordsPerBlock = 8;
  localparam int unsigned WordBytes     = 2;
  localparam int unsigned BlockBytes    = WordsPerBlock * WordBytes;
  localparam int unsigned OffsetW       = $clog2(WordsPerBlock);
  localparam int unsigned CntW          = OffsetW + 1;

endpackage

// File: rtl/fill_counter.sv
// Up-counter with synchronous clear and enable, used for issue and return counts.
module fill_counter #(
  parameter int unsigned Width = 4
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             clr_i,
  input  logic             en_i,
  output logic [Width-1:0] cnt_o
);

  logic [Width-1:0] cnt_q;

  // Clear wins over enable so a fresh fill always starts at zero.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q <= '0;
    end else if (clr_i) begin
      cnt_q <= '0;
    end else if (en_i) begin
      cnt_q <= cnt_q + 1'b1;
    end
  end

  assign cnt_o = cnt_q;

endmodule

// File: rtl/mem_arbiter.sv
// Arbitrates the single pipelined memory port between I-cache fills, D-cache fills
// and D-cache write-through stores.
module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int unsigned WORDS_PER_BLOCK = WordsPerBlock,
  parameter int unsigned ADDR_W          = 16,
  parameter int unsigned DATA_W          = 16
) (
  input  logic                               clk_i,
  input  logic                               rst_ni,
  input  logic                               icache_miss_i,
  input  logic [ADDR_W-1:0]                  icache_miss_addr_i,
  input  logic                               dcache_miss_i,
  input  logic [ADDR_W-1:0]                  dcache_miss_addr_i,
  input  logic                               dcache_wr_req_i,
  input  logic [ADDR_W-1:0]                  dcache_wr_addr_i,
  input  logic [DATA_W-1:0]                  dcache_wr_data_i,
  output logic                               dcache_wr_ack_o,
  output logic                               mem_en_o,
  output logic                               mem_wr_o,
  output logic [ADDR_W-1:0]                  mem_addr_o,
  output logic [DATA_W-1:0]                  mem_wdata_o,
  input  logic [DATA_W-1:0]                  mem_rdata_i,
  input  logic                               mem_rvalid_i,
  output logic                               icache_fill_we_o,
  output logic                               dcache_fill_we_o,
  output logic [DATA_W-1:0]                  fill_data_o,
  output logic [$clog2(WORDS_PER_BLOCK)-1:0] fill_idx_o,
  output logic                               icache_fill_done_o,
  output logic                               dcache_fill_done_o,
  output logic                               busy_o
);

  localparam int unsigned OffW      = $clog2(WORDS_PER_BLOCK);
  localparam int unsigned CntWidth  = OffW + 1;
  localparam int unsigned BlkBytes  = WORDS_PER_BLOCK * WordBytes;

  localparam logic [CntWidth-1:0] NumWords = CntWidth'(WORDS_PER_BLOCK);
  localparam logic [CntWidth-1:0] LastIdx  = CntWidth'(WORDS_PER_BLOCK - 1);
  localparam logic [ADDR_W-1:0]   BaseMask = ~ADDR_W'(BlkBytes - 1);

  arb_state_t          state_q, state_d;
  logic [ADDR_W-1:0]   base_q, base_d;
  logic [CntWidth-1:0] issue_cnt, ret_cnt;
  logic                in_fill, issue_act, ret_en, last_ret, cnt_clr;

  assign in_fill   = (state_q == StFillD) || (state_q == StFillI);
  assign issue_act = in_fill && (issue_cnt < NumWords);
  // Returns outside a fill (idle, store, or after a reset) are dropped here.
  assign ret_en    = in_fill && mem_rvalid_i;
  assign last_ret  = ret_en && (ret_cnt == LastIdx);
  // Counters sit at zero whenever no fill is running, so every grant starts clean.
  assign cnt_clr   = !in_fill;

  fill_counter #(
    .Width (CntWidth)
  ) u_issue_cnt (
    .clk_i  (clk_i),
    .rst_ni (rst_ni),
    .clr_i  (cnt_clr),
    .en_i   (issue_act),
    .cnt_o  (issue_cnt)
  );

  fill_counter #(
    .Width (CntWidth)
  ) u_ret_cnt (
    .clk_i  (clk_i),
    .rst_ni (rst_ni),
    .clr_i  (cnt_clr),
    .en_i   (ret_en),
    .cnt_o  (ret_cnt)
  );

  // State and latched block base address.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= StIdle;
      base_q  <= '0;
    end else begin
      state_q <= state_d;
      base_q  <= base_d;
    end
  end

  // Next state: fixed-priority grant in idle; fills run to their last return.
  always_comb begin
    state_d = state_q;
    base_d  = base_q;
    unique case (state_q)
      StIdle: begin
        if (dcache_wr_req_i) begin
          state_d = StWrite;
        end else if (dcache_miss_i) begin
          state_d = StFillD;
          base_d  = dcache_miss_addr_i & BaseMask;
        end else if (icache_miss_i) begin
          state_d = StFillI;
          base_d  = icache_miss_addr_i & BaseMask;
        end
      end
      StWrite: state_d = StIdle;
      StFillD, StFillI: begin
        if (last_ret) begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // Output decode from registered state, counters and the read-return strobe.
  always_comb begin
    dcache_wr_ack_o    = 1'b0;
    mem_en_o           = 1'b0;
    mem_wr_o           = 1'b0;
    mem_addr_o         = '0;
    mem_wdata_o        = '0;
    icache_fill_we_o   = 1'b0;
    dcache_fill_we_o   = 1'b0;
    icache_fill_done_o = 1'b0;
    dcache_fill_done_o = 1'b0;
    unique case (state_q)
      StWrite: begin
        mem_en_o        = 1'b1;
        mem_wr_o        = 1'b1;
        mem_addr_o      = dcache_wr_addr_i;
        mem_wdata_o     = dcache_wr_data_i;
        dcache_wr_ack_o = 1'b1;
      end
      StFillD, StFillI: begin
        mem_en_o = issue_act;
        if (issue_act) begin
          mem_addr_o = base_q + ADDR_W'({issue_cnt, 1'b0});
        end
        if (state_q == StFillD) begin
          dcache_fill_we_o   = mem_rvalid_i;
          dcache_fill_done_o = last_ret;
        end else begin
          icache_fill_we_o   = mem_rvalid_i;
          icache_fill_done_o = last_ret;
        end
      end
      default: ;
    endcase
  end

  assign fill_data_o = mem_rdata_i;
  assign fill_idx_o  = ret_cnt[OffW-1:0];
  assign busy_o      = (state_q != StIdle);

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter with a fixed-latency (4 cycle) memory model.
module tb_mem_arbiter;

  logic        clk, rst_n;
  logic        icache_miss, dcache_miss, dcache_wr_req;
  logic [15:0] icache_miss_addr, dcache_miss_addr, dcache_wr_addr, dcache_wr_data;
  logic        dcache_wr_ack, mem_en, mem_wr, mem_rvalid;
  logic [15:0] mem_addr, mem_wdata, mem_rdata, fill_data;
  logic        icache_fill_we, dcache_fill_we, icache_fill_done, dcache_fill_done, busy;
  logic [2:0]  fill_idx;

  int n_assert = 0;
  int n_fail   = 0;

  // Memory pipeline: slot j holds a read issued j+1 cycles ago.
  logic        pv[4];
  logic [15:0] pa[4];

  mem_arbiter #(
    .WORDS_PER_BLOCK (8),
    .ADDR_W          (16),
    .DATA_W          (16)
  ) dut (
    .clk_i              (clk),
    .rst_ni             (rst_n),
    .icache_miss_i      (icache_miss),
    .icache_miss_addr_i (icache_miss_addr),
    .dcache_miss_i      (dcache_miss),
    .dcache_miss_addr_i (dcache_miss_addr),
    .dcache_wr_req_i    (dcache_wr_req),
    .dcache_wr_addr_i   (dcache_wr_addr),
    .dcache_wr_data_i   (dcache_wr_data),
    .dcache_wr_ack_o    (dcache_wr_ack),
    .mem_en_o           (mem_en),
    .mem_wr_o           (mem_wr),
    .mem_addr_o         (mem_addr),
    .mem_wdata_o        (mem_wdata),
    .mem_rdata_i        (mem_rdata),
    .mem_rvalid_i       (mem_rvalid),
    .icache_fill_we_o   (icache_fill_we),
    .dcache_fill_we_o   (dcache_fill_we),
    .fill_data_o        (fill_data),
    .fill_idx_o         (fill_idx),
    .icache_fill_done_o (icache_fill_done),
    .dcache_fill_done_o (dcache_fill_done),
    .busy_o             (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1, "watchdog");
  end

  function automatic logic [15:0] rd(input logic [15:0] a);
    return a ^ 16'h5A5A;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Advance one cycle; memory returns for the new cycle are driven before checks.
  task automatic step();
    logic        cmd;
    logic [15:0] a;
    @(negedge clk);
    cmd = mem_en && !mem_wr;
    a   = mem_addr;
    @(posedge clk);
    #1;
    for (int j = 3; j > 0; j--) begin
      pv[j] = pv[j-1];
      pa[j] = pa[j-1];
    end
    pv[0]      = cmd;
    pa[0]      = a;
    mem_rvalid = pv[3];
    mem_rdata  = pv[3] ? rd(pa[3]) : 16'h0000;
    #1;
  endtask

  initial begin
    int en_cnt, we_cnt;
    for (int j = 0; j < 4; j++) begin
      pv[j] = 1'b0;
      pa[j] = '0;
    end
    rst_n = 1'b0;
    icache_miss = 1'b0; dcache_miss = 1'b0; dcache_wr_req = 1'b0;
    icache_miss_addr = '0; dcache_miss_addr = '0;
    dcache_wr_addr = '0; dcache_wr_data = '0;
    mem_rvalid = 1'b0; mem_rdata = '0;

    // Reset state
    step(); step();
    chk("rst busy", busy, 0);
    chk("rst mem_en", mem_en, 0);
    chk("rst mem_addr", mem_addr, 0);
    chk("rst fill_idx", fill_idx, 0);
    rst_n = 1'b1;
    step();
    chk("idle busy", busy, 0);

    // T1: lone I-miss at 0x1234
    icache_miss = 1'b1; icache_miss_addr = 16'h1234;
    for (int c = 1; c <= 13; c++) begin
      step();
      chk($sformatf("t1 mem_en c%0d", c), mem_en, c <= 8);
      if (c <= 8) begin
        chk($sformatf("t1 addr c%0d", c), mem_addr, 16'(16'h1230 + 2 * (c - 1)));
        chk($sformatf("t1 mem_wr c%0d", c), mem_wr, 0);
      end
      chk($sformatf("t1 i_we c%0d", c), icache_fill_we, (c >= 5) && (c <= 12));
      if (c >= 5 && c <= 12) begin
        chk($sformatf("t1 idx c%0d", c), fill_idx, c - 5);
        chk($sformatf("t1 data c%0d", c), fill_data, rd(16'(16'h1230 + 2 * (c - 5))));
      end
      chk($sformatf("t1 i_done c%0d", c), icache_fill_done, c == 12);
      chk($sformatf("t1 d_we c%0d", c), dcache_fill_we, 0);
      chk($sformatf("t1 busy c%0d", c), busy, c <= 12);
      if (c == 12) icache_miss = 1'b0;
    end

    // T2: simultaneous I-miss 0x0100 and D-miss 0x2008; D first
    icache_miss = 1'b1; icache_miss_addr = 16'h0100;
    dcache_miss = 1'b1; dcache_miss_addr = 16'h2008;
    for (int c = 1; c <= 26; c++) begin
      step();
      chk($sformatf("t2 mem_en c%0d", c), mem_en, (c <= 8) || (c >= 14 && c <= 21));
      if (c <= 8)
        chk($sformatf("t2 d addr c%0d", c), mem_addr, 16'(16'h2000 + 2 * (c - 1)));
      if (c >= 14 && c <= 21)
        chk($sformatf("t2 i addr c%0d", c), mem_addr, 16'(16'h0100 + 2 * (c - 14)));
      chk($sformatf("t2 d_we c%0d", c), dcache_fill_we, (c >= 5) && (c <= 12));
      chk($sformatf("t2 i_we c%0d", c), icache_fill_we, (c >= 18) && (c <= 25));
      if (c >= 5 && c <= 12) chk($sformatf("t2 d idx c%0d", c), fill_idx, c - 5);
      if (c >= 18 && c <= 25) chk($sformatf("t2 i idx c%0d", c), fill_idx, c - 18);
      chk($sformatf("t2 d_done c%0d", c), dcache_fill_done, c == 12);
      chk($sformatf("t2 i_done c%0d", c), icache_fill_done, c == 25);
      chk($sformatf("t2 busy c%0d", c), busy, (c <= 12) || (c >= 14 && c <= 25));
      if (c == 12) dcache_miss = 1'b0;
      if (c == 25) icache_miss = 1'b0;
    end

    // T3: store beats a D-miss in the same cycle
    dcache_wr_req = 1'b1; dcache_wr_addr = 16'h4002; dcache_wr_data = 16'hBEEF;
    dcache_miss = 1'b1; dcache_miss_addr = 16'h3006;
    step();
    chk("t3 wr mem_en", mem_en, 1);
    chk("t3 wr mem_wr", mem_wr, 1);
    chk("t3 wr addr", mem_addr, 16'h4002);
    chk("t3 wr data", mem_wdata, 16'hBEEF);
    chk("t3 wr ack", dcache_wr_ack, 1);
    dcache_wr_req = 1'b0;
    step();
    chk("t3 gap ack", dcache_wr_ack, 0);
    chk("t3 gap busy", busy, 0);
    chk("t3 gap mem_en", mem_en, 0);
    for (int c = 3; c <= 15; c++) begin
      step();
      chk($sformatf("t3 mem_en c%0d", c), mem_en, c <= 10);
      if (c <= 10) chk($sformatf("t3 addr c%0d", c), mem_addr, 16'(16'h3000 + 2 * (c - 3)));
      chk($sformatf("t3 mem_wr c%0d", c), mem_wr, 0);
      chk($sformatf("t3 d_we c%0d", c), dcache_fill_we, (c >= 7) && (c <= 14));
      chk($sformatf("t3 d_done c%0d", c), dcache_fill_done, c == 14);
      chk($sformatf("t3 busy c%0d", c), busy, c <= 14);
      if (c == 14) dcache_miss = 1'b0;
    end

    // T4: store raised mid I-fill waits for the fill plus one idle cycle
    icache_miss = 1'b1; icache_miss_addr = 16'h0040;
    for (int c = 1; c <= 15; c++) begin
      step();
      chk($sformatf("t4 ack c%0d", c), dcache_wr_ack, c == 14);
      chk($sformatf("t4 mem_wr c%0d", c), mem_wr, c == 14);
      chk($sformatf("t4 mem_en c%0d", c), mem_en, (c <= 8) || (c == 14));
      if (c <= 8) chk($sformatf("t4 addr c%0d", c), mem_addr, 16'(16'h0040 + 2 * (c - 1)));
      chk($sformatf("t4 i_done c%0d", c), icache_fill_done, c == 12);
      chk($sformatf("t4 busy c%0d", c), busy, (c <= 12) || (c == 14));
      if (c == 14) begin
        chk("t4 wr addr", mem_addr, 16'h5554);
        chk("t4 wr data", mem_wdata, 16'h1357);
        dcache_wr_req = 1'b0;
      end
      if (c == 3) begin
        dcache_wr_req = 1'b1; dcache_wr_addr = 16'h5554; dcache_wr_data = 16'h1357;
      end
      if (c == 12) icache_miss = 1'b0;
    end

    // T5: I-miss dropped in cycle 2 still completes the whole block
    icache_miss = 1'b1; icache_miss_addr = 16'h0A00;
    en_cnt = 0; we_cnt = 0;
    for (int c = 1; c <= 13; c++) begin
      step();
      if (mem_en) en_cnt++;
      if (icache_fill_we) begin
        chk($sformatf("t5 idx c%0d", c), fill_idx, we_cnt);
        we_cnt++;
      end
      chk($sformatf("t5 i_done c%0d", c), icache_fill_done, c == 12);
      if (c == 2) icache_miss = 1'b0;
    end
    chk("t5 issued", en_cnt, 8);
    chk("t5 returned", we_cnt, 8);
    chk("t5 idle", busy, 0);

    // T6: reset in cycle 6 of a D fill
    dcache_miss = 1'b1; dcache_miss_addr = 16'h7010;
    for (int c = 1; c <= 5; c++) begin
      step();
      chk($sformatf("t6 mem_en c%0d", c), mem_en, 1);
    end
    step();
    chk("t6 d_we before rst", dcache_fill_we, 1);
    chk("t6 idx before rst", fill_idx, 1);
    rst_n = 1'b0; dcache_miss = 1'b0;
    #1;
    chk("t6 rst mem_en", mem_en, 0);
    chk("t6 rst mem_wr", mem_wr, 0);
    chk("t6 rst mem_addr", mem_addr, 0);
    chk("t6 rst wdata", mem_wdata, 0);
    chk("t6 rst ack", dcache_wr_ack, 0);
    chk("t6 rst d_we", dcache_fill_we, 0);
    chk("t6 rst i_we", icache_fill_we, 0);
    chk("t6 rst idx", fill_idx, 0);
    chk("t6 rst d_done", dcache_fill_done, 0);
    chk("t6 rst i_done", icache_fill_done, 0);
    chk("t6 rst busy", busy, 0);
    for (int c = 7; c <= 10; c++) begin
      step();
      if (c == 7) rst_n = 1'b1;
      chk($sformatf("t6 late d_we c%0d", c), dcache_fill_we, 0);
      chk($sformatf("t6 late d_done c%0d", c), dcache_fill_done, 0);
      chk($sformatf("t6 late idx c%0d", c), fill_idx, 0);
      chk($sformatf("t6 late busy c%0d", c), busy, 0);
    end
    icache_miss = 1'b1; icache_miss_addr = 16'h0300;
    for (int c = 11; c <= 23; c++) begin
      step();
      chk($sformatf("t6 new i_we c%0d", c), icache_fill_we, (c >= 15) && (c <= 22));
      if (c >= 15 && c <= 22) chk($sformatf("t6 new idx c%0d", c), fill_idx, c - 15);
      if (c <= 18) chk($sformatf("t6 new addr c%0d", c), mem_addr, 16'(16'h0300 + 2 * (c - 11)));
      chk($sformatf("t6 new i_done c%0d", c), icache_fill_done, c == 22);
      chk($sformatf("t6 new busy c%0d", c), busy, c <= 22);
      if (c == 22) icache_miss = 1'b0;
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/mem_arbiter.md
# mem_arbiter

Shares the single pipelined main-memory port between the instruction-cache and data-cache controllers. It sequences 8-word block fills on a cache miss and single-word write-through stores from the data side. It sits between the two cache FSMs and main memory. The pipeline's stall logic reads `busy` and the per-requester fill signals.

## Interface
- `WORDS_PER_BLOCK`, 8: words per cache block; power of two.
- `ADDR_W`, 16: byte-address width.
- `DATA_W`, 16: word width.
- `clk` in 1: system clock; all state on rising edge.
- `rst_n` in 1: asynchronous, active-low reset. One clock domain; reset polarity and asynchronous behaviour are fixed.
- `icache_miss` in 1: level request; held by the I-cache until `icache_fill_done`.
- `icache_miss_addr` in ADDR_W: any byte address within the missing block.
- `dcache_miss` in 1, `dcache_miss_addr` in ADDR_W: same, for the D-cache.
- `dcache_wr_req` in 1: level write-through request; held until `dcache_wr_ack`.
- `dcache_wr_addr` in ADDR_W, `dcache_wr_data` in DATA_W: store address and data.
- `dcache_wr_ack` out 1: one-cycle pulse on the cycle the write issues.
- `mem_en` out 1, `mem_wr` out 1, `mem_addr` out ADDR_W, `mem_wdata` out DATA_W: memory command. One command per cycle.
- `mem_rdata` in DATA_W, `mem_rvalid` in 1: read return. In order, fixed unknown latency, one word per pulse.
- `icache_fill_we`, `dcache_fill_we` out 1: write the current word into that cache.
- `fill_data` out DATA_W: equals `mem_rdata`. Shared by both caches.
- `fill_idx` out log2(WORDS_PER_BLOCK): word offset of the current return.
- `icache_fill_done`, `dcache_fill_done` out 1: pulse coincident with the last word's fill_we.
- `busy` out 1: high in any state other than IDLE.

## Operation
- States: IDLE, WRITE, FILL_D, FILL_I.
- Arbitration happens only in IDLE. Priority order: `dcache_wr_req`, then `dcache_miss`, then `icache_miss`.
- WRITE lasts one cycle.
  - Outputs: `mem_en`=1, `mem_wr`=1, `mem_addr`=`dcache_wr_addr`, `mem_wdata`=`dcache_wr_data`, `dcache_wr_ack`=1.
  - Next state: IDLE.
- FILL_x:
  - Base address is the latched miss address with the low log2(WORDS_PER_BLOCK)+1 bits cleared. Latch on grant.
  - Issue phase: issue counter k runs 0..WORDS_PER_BLOCK-1. `mem_en`=1, `mem_wr`=0, `mem_addr`=base+2k, one per cycle, no gaps.
  - Return phase: the return counter increments on each `mem_rvalid`. `fill_idx` equals the return counter. `x_fill_we`=`mem_rvalid`.
  - The last return asserts `x_fill_done`. Next state: IDLE.
  - Issue and return phases overlap.
- Fills are non-preemptible. New requests and deasserted misses are ignored until IDLE, and the fill always completes.
- `mem_rvalid` in IDLE or WRITE is ignored: no fill_we and no counter change.
- Returns beyond WORDS_PER_BLOCK cannot occur, because the state has already left FILL.
- Counter widths: log2(WORDS_PER_BLOCK)+1 bits. Address arithmetic wraps modulo 2^ADDR_W; no carry out.

## Timing
- Reset value of every output is 0. State resets to IDLE and counters to 0, taking effect immediately on the `rst_n` assertion.
- Reset mid-fill abandons the fill; no done pulse is generated. Returns that arrive after reset are ignored.
- A request sampled high in IDLE in cycle 0 gives a grant state in cycle 1.
  - For a fill, `mem_en` is high in cycles 1..WORDS_PER_BLOCK.
  - For a write, `mem_en` is high in cycle 1 only.
- With memory latency L, returns arrive in cycles 1+L..WORDS_PER_BLOCK+L, and IDLE is reached the cycle after the last return.
- Back-to-back requests always have one IDLE cycle between grants.
- `fill_data`, `fill_we`, and `fill_done` are combinational from `mem_rvalid`/`mem_rdata` and registered state. Command outputs decode directly from registered state and counters.

## Structure
- Package `mem_arb_pkg` holds:
  - the state enum `arb_state_t`;
  - localparams for block byte size, offset width and counter width.
- One sub-module, `fill_counter`: a parameterised up-counter with synchronous clear and enable, and an async active-low reset. Instantiate it twice, for the issue count and the return count.

## Test plan
- Lone I-miss at 0x1234, memory latency 4:
  - `mem_addr` is 0x1230, 0x1232 … 0x123E in cycles 1..8, with `mem_wr`=0.
  - `icache_fill_we` is high in cycles 5..12 with `fill_idx` 0..7.
  - `icache_fill_done` is high in cycle 12 only; `busy` is high in cycles 1..12.
- I-miss at 0x0100 and D-miss at 0x2008 in the same cycle:
  - The D fill covers 0x2000..0x200E first.
  - After one IDLE cycle, the I fill covers 0x0100..0x010E.
- `dcache_wr_req` (0x4002, 0xBEEF) and `dcache_miss` in the same cycle:
  - Cycle 1: `mem_wr`=1, `mem_wdata`=0xBEEF, `dcache_wr_ack` pulse.
  - The D fill is granted in cycle 3.
- `dcache_wr_req` raised in cycle 3 of an I fill: no ack until the fill completes, then the write issues after one IDLE cycle.
- `icache_miss` dropped in cycle 2 of its fill: all 8 words are still issued and returned, and done still pulses.
- `rst_n` asserted in cycle 6 of a fill:
  - All outputs are 0 immediately.
  - Subsequent `mem_rvalid` pulses produce no fill_we.
  - A new miss after reset starts cleanly at `fill_idx` 0.
